// File: rtl/lfsr_seq_checker.sv
// -----------------------------------------------------------------------------
// lfsr_seq_checker
//
// Downstream monitor for a W-bit LFSR / sequence generator. Every valid word
// is compared against the successor predicted from the previous word:
//   exp = {prev_data[W-2:0], ^(prev_data & TAPS)}
// The all-zero word is never a legal successor. After LOCK_CNT consecutive
// correct predictions the checker declares lock. While locked, every
// mismatch is reported and counted. LOSS_CNT consecutive mismatches drop it
// back to SEARCH. The checker always re-seeds from the word it just saw, so
// it re-acquires a generator that has jumped to another point in its cycle.
//
// Optional build macro:
//   SEQ_CHK_STUCK_EN - adds output 'stuck', which flags two consecutive
//                      seeded beats that carry the same word.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   in_data carries a new generator word this cycle
//   in_data    in   [W-1:0] generator word
//   clr_err    in   synchronous clear of err_count (wins over an increment)
//   locked     out  checker is in LOCKED
//   lock_pulse out  one-cycle pulse on SEARCH->LOCKED
//   loss_pulse out  one-cycle pulse on LOCKED->SEARCH
//   err_pulse  out  one-cycle pulse per mismatch beat while LOCKED
//   err_count  out  [CW-1:0] saturating mismatch count
//   stuck      out  (SEQ_CHK_STUCK_EN only) repeated-word indicator
// All outputs are registered and change the cycle after the sampling edge.
// -----------------------------------------------------------------------------
module lfsr_seq_checker #(
    parameter int             W        = 4,
    parameter logic [W-1:0]   TAPS     = 4'b1100,
    parameter int             LOCK_CNT = 4,
    parameter int             LOSS_CNT = 3,
    parameter int             CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          clr_err,
    output logic          locked,
    output logic          lock_pulse,
    output logic          loss_pulse,
    output logic          err_pulse,
    output logic [CW-1:0] err_count
`ifdef SEQ_CHK_STUCK_EN
    ,
    output logic          stuck
`endif
);

    // Run counters only need to reach their saturation value.
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int NW = $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_CNT);
    localparam logic [NW-1:0] MISS_MAX  = NW'(LOSS_CNT);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           seeded;
    logic [W-1:0]   prev_data;
    logic [MW-1:0]  match_run;
    logic [NW-1:0]  miss_run;

    logic [W-1:0]   exp_data;
    logic           cmp_beat;     // beat that is actually compared
    logic           match;
    logic           match_full;   // this match brings match_run to LOCK_CNT
    logic           miss_full;    // this mismatch brings miss_run to LOSS_CNT

    logic           lock_pulse_d;
    logic           loss_pulse_d;
    logic           err_pulse_d;

    // ------------------------------------------------------------------
    // Prediction and compare
    // ------------------------------------------------------------------
    always_comb begin
        exp_data   = {prev_data[W-2:0], ^(prev_data & TAPS)};
        cmp_beat   = in_valid && seeded;
        // A zero word would freeze an XOR LFSR, so it never counts as a match.
        match      = (in_data == exp_data) && (in_data != '0);
        match_full = (match_run >= MATCH_MAX - MW'(1));
        miss_full  = (miss_run  >= MISS_MAX  - NW'(1));
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking (<=) assignments so
    // every flop samples the pre-edge values, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: each combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            SEARCH: if (cmp_beat && match && match_full)   state_next = LOCKED;
            LOCKED: if (cmp_beat && !match && miss_full)   state_next = SEARCH;
            default:                                       state_next = SEARCH;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (registered below)
    // ------------------------------------------------------------------
    always_comb begin
        lock_pulse_d = (state == SEARCH) && (state_next == LOCKED);
        loss_pulse_d = (state == LOCKED) && (state_next == SEARCH);
        // The loss beat itself is still a locked mismatch and is reported.
        err_pulse_d  = (state == LOCKED) && cmp_beat && !match;
    end

    // ------------------------------------------------------------------
    // Seed, previous word and run counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seeded    <= 1'b0;
            prev_data <= '0;
            match_run <= '0;
            miss_run  <= '0;
        end else if (in_valid) begin
            // Always follow the incoming stream so a jump re-seeds the model.
            prev_data <= in_data;
            seeded    <= 1'b1;
            if (seeded) begin
                if (match) begin
                    match_run <= match_full ? MATCH_MAX : match_run + MW'(1);
                    miss_run  <= '0;
                end else begin
                    miss_run  <= miss_full ? MISS_MAX : miss_run + NW'(1);
                    match_run <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_pulse <= 1'b0;
            loss_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
        end else begin
            lock_pulse <= lock_pulse_d;
            loss_pulse <= loss_pulse_d;
            err_pulse  <= err_pulse_d;
            if (clr_err) begin
                err_count <= '0;
            end else if (err_pulse_d && (err_count != '1)) begin
                err_count <= err_count + CW'(1);
            end
        end
    end

    assign locked = (state == LOCKED);

`ifdef SEQ_CHK_STUCK_EN
    // Set on a compared beat equal to the previous word, cleared on the next
    // compared beat that differs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuck <= 1'b0;
        end else if (cmp_beat) begin
            stuck <= (in_data == prev_data);
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_seq_checker
//
// Two checker instances: 'a' with default parameters, 'b' with CW=2 and
// LOSS_CNT=8 for err_count saturation. Directed beats are applied on the
// falling edge; each beat pushes its hand-computed expected outputs into a
// per-instance queue. Monitors pop one entry per checked cycle and compare
// on the following falling edge.
// -----------------------------------------------------------------------------
module tb_lfsr_seq_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance a
    logic       in_valid_a = 1'b0;
    logic [3:0] in_data_a  = '0;
    logic       clr_a      = 1'b0;
    logic       locked_a, lock_pulse_a, loss_pulse_a, err_pulse_a;
    logic [7:0] err_count_a;
    // Instance b
    logic       in_valid_b = 1'b0;
    logic [3:0] in_data_b  = '0;
    logic       clr_b      = 1'b0;
    logic       locked_b, lock_pulse_b, loss_pulse_b, err_pulse_b;
    logic [1:0] err_count_b;
`ifdef SEQ_CHK_STUCK_EN
    logic       stuck_a, stuck_b;
`endif

    lfsr_seq_checker u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid_a),
        .in_data    (in_data_a),
        .clr_err    (clr_a),
        .locked     (locked_a),
        .lock_pulse (lock_pulse_a),
        .loss_pulse (loss_pulse_a),
        .err_pulse  (err_pulse_a),
        .err_count  (err_count_a)
`ifdef SEQ_CHK_STUCK_EN
        ,
        .stuck      (stuck_a)
`endif
    );

    lfsr_seq_checker #(.LOSS_CNT(8), .CW(2)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid_b),
        .in_data    (in_data_b),
        .clr_err    (clr_b),
        .locked     (locked_b),
        .lock_pulse (lock_pulse_b),
        .loss_pulse (loss_pulse_b),
        .err_pulse  (err_pulse_b),
        .err_count  (err_count_b)
`ifdef SEQ_CHK_STUCK_EN
        ,
        .stuck      (stuck_b)
`endif
    );

    typedef struct {
        string nm;
        logic  l;
        logic  lp;
        logic  lsp;
        logic  ep;
        int    cnt;
        logic  st;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int   errors = 0;
    int   checks = 0;

    logic chk_a  = 1'b0;
    logic chk_b  = 1'b0;
    logic pend_a = 1'b0;
    logic pend_b = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Drivers: one call = one cycle of stimulus plus its expectation
    // ------------------------------------------------------------------
    task automatic step_a(input string nm, input logic v, input logic [3:0] d, input logic c,
                          input logic l, input logic lp, input logic lsp, input logic ep,
                          input int cnt, input logic st);
        exp_t e;
        @(negedge clk);
        in_valid_a = v;
        in_data_a  = d;
        clr_a      = c;
        chk_a      = 1'b1;
        e = '{nm: nm, l: l, lp: lp, lsp: lsp, ep: ep, cnt: cnt, st: st};
        q_a.push_back(e);
    endtask

    task automatic step_b(input string nm, input logic [3:0] d,
                          input logic l, input logic lp, input logic ep,
                          input int cnt, input logic st);
        exp_t e;
        @(negedge clk);
        in_valid_b = 1'b1;
        in_data_b  = d;
        clr_b      = 1'b0;
        chk_b      = 1'b1;
        e = '{nm: nm, l: l, lp: lp, lsp: 1'b0, ep: ep, cnt: cnt, st: st};
        q_b.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        clr_a      = 1'b0;
        clr_b      = 1'b0;
        chk_a      = 1'b0;
        chk_b      = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        pend_a <= chk_a;
        pend_b <= chk_b;
    end

    always @(negedge clk) begin
        exp_t e;
        if (pend_a) begin
            if (q_a.size() == 0) begin
                check("a.queue_underflow", 32'd1, 32'd0);
            end else begin
                e = q_a.pop_front();
                check({"a.", e.nm, ".locked"},     locked_a,     e.l);
                check({"a.", e.nm, ".lock_pulse"}, lock_pulse_a, e.lp);
                check({"a.", e.nm, ".loss_pulse"}, loss_pulse_a, e.lsp);
                check({"a.", e.nm, ".err_pulse"},  err_pulse_a,  e.ep);
                check({"a.", e.nm, ".err_count"},  32'(err_count_a), e.cnt);
`ifdef SEQ_CHK_STUCK_EN
                check({"a.", e.nm, ".stuck"},      stuck_a,      e.st);
`endif
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (pend_b) begin
            if (q_b.size() == 0) begin
                check("b.queue_underflow", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                check({"b.", e.nm, ".locked"},     locked_b,     e.l);
                check({"b.", e.nm, ".lock_pulse"}, lock_pulse_b, e.lp);
                check({"b.", e.nm, ".loss_pulse"}, loss_pulse_b, e.lsp);
                check({"b.", e.nm, ".err_pulse"},  err_pulse_b,  e.ep);
                check({"b.", e.nm, ".err_count"},  32'(err_count_b), e.cnt);
`ifdef SEQ_CHK_STUCK_EN
                check({"b.", e.nm, ".stuck"},      stuck_b,      e.st);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [3:0] run [11];
        run = '{4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100,
                4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.locked",     locked_a,     1'b0);
        check("reset.lock_pulse", lock_pulse_a, 1'b0);
        check("reset.err_pulse",  err_pulse_a,  1'b0);
        check("reset.err_count",  32'(err_count_a), 32'd0);
        rst = 1'b0;

        // Acquire lock: first beat seeds, 4th match locks
        step_a("seed",   1, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        step_a("m1",     1, 4'b0010, 0, 0, 0, 0, 0, 0, 0);
        step_a("m2",     1, 4'b0100, 0, 0, 0, 0, 0, 0, 0);
        step_a("m3",     1, 4'b1001, 0, 0, 0, 0, 0, 0, 0);
        step_a("lock",   1, 4'b0011, 0, 1, 1, 0, 0, 0, 0);
        step_a("idle",   0, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        step_a("m_0110", 1, 4'b0110, 0, 1, 0, 0, 0, 0, 0);

        // Zero word instead of 1101; re-seed from 0000 then 1101 also misses
        step_a("zero",   1, 4'b0000, 0, 1, 0, 0, 1, 1, 0);
        step_a("reseed", 1, 4'b1101, 0, 1, 0, 0, 1, 2, 0);
        step_a("m_1010", 1, 4'b1010, 0, 1, 0, 0, 0, 2, 0);
        foreach (run[i]) step_a("run", 1, run[i], 0, 1, 0, 0, 0, 2, 0);
        // Clear on a matching beat
        step_a("clr_match", 1, 4'b0011, 1, 1, 0, 0, 0, 0, 0);

        // Three mismatches: loss on the third, each one counted
        step_a("miss1",  1, 4'b1111, 0, 1, 0, 0, 1, 1, 0);
        step_a("miss2",  1, 4'b1111, 0, 1, 0, 0, 1, 2, 1);
        step_a("loss",   1, 4'b1111, 0, 0, 0, 1, 1, 3, 1);

        // Relock from re-seed 1111
        step_a("r1",     1, 4'b1110, 0, 0, 0, 0, 0, 3, 0);
        step_a("r2",     1, 4'b1100, 0, 0, 0, 0, 0, 3, 0);
        step_a("r3",     1, 4'b1000, 0, 0, 0, 0, 0, 3, 0);
        step_a("relock", 1, 4'b0001, 0, 1, 1, 0, 0, 3, 0);
        step_a("r5",     1, 4'b0010, 0, 1, 0, 0, 0, 3, 0);

        // Clear wins over a simultaneous locked mismatch
        step_a("clr_miss", 1, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
        step_a("e1",     1, 4'b0100, 0, 1, 0, 0, 1, 1, 0);
        step_a("ok1",    1, 4'b1001, 0, 1, 0, 0, 0, 1, 0);
        step_a("e2",     1, 4'b0000, 0, 1, 0, 0, 1, 2, 0);
        step_a("e3",     1, 4'b0100, 0, 1, 0, 0, 1, 3, 0);
        step_a("ok2",    1, 4'b1001, 0, 1, 0, 0, 0, 3, 0);
        step_a("e4",     1, 4'b0000, 0, 1, 0, 0, 1, 4, 0);
        step_a("e5",     1, 4'b0100, 0, 1, 0, 0, 1, 5, 0);
        step_a("ok3",    1, 4'b1001, 0, 1, 0, 0, 0, 5, 0);
        idle();

        // Instance b: CW=2 saturates at 3, LOSS_CNT=8 keeps it locked
        step_b("seed",   4'b0001, 0, 0, 0, 0, 0);
        step_b("m1",     4'b0010, 0, 0, 0, 0, 0);
        step_b("m2",     4'b0100, 0, 0, 0, 0, 0);
        step_b("m3",     4'b1001, 0, 0, 0, 0, 0);
        step_b("lock",   4'b0011, 1, 1, 0, 0, 0);
        step_b("sat1",   4'b0000, 1, 0, 1, 1, 0);
        step_b("sat2",   4'b0000, 1, 0, 1, 2, 1);
        step_b("sat3",   4'b0000, 1, 0, 1, 3, 1);
        step_b("sat4",   4'b0000, 1, 0, 1, 3, 1);
        step_b("sat5",   4'b0000, 1, 0, 1, 3, 1);
        idle();

        // Asynchronous reset while a is locked with err_count=5
        @(negedge clk);
        check("pre_rst.locked",    locked_a, 1'b1);
        check("pre_rst.err_count", 32'(err_count_a), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("rst.locked",     locked_a,     1'b0);
        check("rst.err_count",  32'(err_count_a), 32'd0);
        check("rst.lock_pulse", lock_pulse_a, 1'b0);
        check("rst.loss_pulse", loss_pulse_a, 1'b0);
        check("rst.err_pulse",  err_pulse_a,  1'b0);
        check("rst.b_locked",   locked_b,     1'b0);
        @(negedge clk);
        rst = 1'b0;

        // First beat after reset only seeds; SEARCH mismatches are silent
        step_a("post_seed", 1, 4'b0011, 0, 0, 0, 0, 0, 0, 0);
        step_a("post_m1",   1, 4'b0110, 0, 0, 0, 0, 0, 0, 0);
        step_a("srch_miss", 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        step_a("rep1",      1, 4'b1001, 0, 0, 0, 0, 0, 0, 0);
        step_a("rep2",      1, 4'b1001, 0, 0, 0, 0, 0, 0, 1);
        step_a("unrep",     1, 4'b0011, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        check("a.queue_drained", q_a.size(), 32'd0);
        check("b.queue_drained", q_b.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
